// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizing helpers for the asynchronous SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RD_ACC,
    WR_PULSE,
    WR_HOLD,
    TURN
  } state_t;

  function automatic int unsigned lane_count(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter timing the RD_ACC and WR_PULSE phases; done while the count is zero.
module sram_wait_cnt #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/sram_async_ctrl.sv
// Single-request asynchronous SRAM controller with registered strobes.
// Define SRAM_CTRL_TURNAROUND_EN to insert one bus-idle TURN cycle after every read.
module sram_async_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [ADDR_W-1:0]     sram_a,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [DATA_W/8-1:0]   sram_be_n,
  output logic [DATA_W-1:0]     sram_dq_o,
  output logic                  sram_dq_oe,
  input  logic [DATA_W-1:0]     sram_dq_i
);

  localparam int unsigned LANES = lane_count(DATA_W);
  localparam int unsigned CNT_W = cnt_width((RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT);

  state_t            state;
  logic              we_r;
  logic [LANES-1:0]  be_r;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_done;
  logic [DATA_W-1:0] lane_mask;

  always_comb begin
    cnt_load = (state == SETUP);
    cnt_val  = we_r ? CNT_W'(WR_WAIT) : CNT_W'(RD_WAIT);
  end

  always_comb begin
    lane_mask = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_mask[8*i +: 8] = {8{be_r[i]}};
    end
  end

  sram_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      we_r       <= 1'b0;
      be_r       <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      sram_a     <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= '1;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state      <= SETUP;
            req_ready  <= 1'b0;
            we_r       <= req_we;
            be_r       <= req_be;
            sram_a     <= req_addr;
            sram_be_n  <= ~req_be;
            sram_dq_o  <= req_wdata;
            sram_dq_oe <= req_we;
            sram_ce_n  <= 1'b0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        SETUP: begin
          if (we_r) begin
            state     <= WR_PULSE;
            // An all-lanes-off write still walks the full timing, just without a strobe.
            sram_we_n <= (be_r == '0);
          end else begin
            state     <= RD_ACC;
            sram_oe_n <= 1'b0;
          end
        end
        RD_ACC: begin
          if (cnt_done) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= sram_dq_i & lane_mask;
            sram_oe_n <= 1'b1;
            sram_ce_n <= 1'b1;
`ifdef SRAM_CTRL_TURNAROUND_EN
            state     <= TURN;
`else
            state     <= IDLE;
            req_ready <= 1'b1;
`endif
          end
        end
        WR_PULSE: begin
          if (cnt_done) begin
            state     <= WR_HOLD;
            sram_we_n <= 1'b1;
          end
        end
        WR_HOLD: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          sram_ce_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
        TURN: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_async_ctrl.md
SRAM_ASYNC_CTRL -- requirements
Module: sram_async_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, SRAM data width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 18, SRAM word-address width.
REQ-003 SHALL have parameter RD_WAIT, default 1, extra read-access cycles (>=0).
REQ-004 SHALL have parameter WR_WAIT, default 1, extra write-pulse cycles (>=0).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1, request present.
REQ-008 SHALL have port req_ready, output, 1, controller can accept.
REQ-009 SHALL have port req_we, input, 1, 1=write, 0=read.
REQ-010 SHALL have port req_addr, input, ADDR_W, word address.
REQ-011 SHALL have port req_wdata, input, DATA_W, write data.
REQ-012 SHALL have port req_be, input, DATA_W/8, byte-lane enables, bit i = bits 8i+7:8i.
REQ-013 SHALL have port rsp_valid, output, 1, one-cycle read-data strobe.
REQ-014 SHALL have port rsp_rdata, output, DATA_W, read data.
REQ-015 SHALL have ports sram_a (output, ADDR_W), sram_ce_n, sram_oe_n, sram_we_n (output, 1), sram_be_n (output, DATA_W/8, generalised LB_/UB_).
REQ-016 SHALL have ports sram_dq_o (output, DATA_W), sram_dq_oe (output, 1), sram_dq_i (input, DATA_W); tristate is resolved at top level.

Function
REQ-017 SHALL accept a request on a rising edge with req_valid&&req_ready, registering addr/we/wdata/be.
REQ-018 SHALL run FSM states IDLE, SETUP, RD_ACC, WR_PULSE, WR_HOLD, TURN; req_ready=1 only in IDLE.
REQ-019 SHALL go IDLE->SETUP on accept; SETUP lasts 1 cycle: ce_n=0, sram_a/sram_be_n driven, oe_n=1, we_n=1.
REQ-020 SHALL go SETUP->RD_ACC for reads: oe_n=0 for RD_WAIT+1 cycles; sram_dq_i captured on the edge ending the last RD_ACC cycle.
REQ-021 SHALL raise rsp_valid for exactly one cycle starting at the (RD_WAIT+2)th edge after the accepting edge; lanes with req_be=0 return 0 in rsp_rdata.
REQ-022 SHALL go SETUP->WR_PULSE for writes: sram_dq_oe=1 from SETUP through WR_HOLD; we_n=0 for WR_WAIT+1 cycles; WR_HOLD 1 cycle with we_n=1, ce_n=0, data held; then IDLE.
REQ-023 SHALL, for a write with req_be all-zero, keep we_n=1 throughout yet follow identical state timing.
REQ-024 SHALL never assert oe_n=0 and sram_dq_oe=1 in the same cycle; SHALL never assert we_n=0 while oe_n=0.
REQ-025 SHALL return to IDLE with ce_n=1, all strobes high, sram_dq_oe=0 whenever no transfer is active.
REQ-026 SHALL accept any address including all-ones; no wrap or range check.
REQ-027 SHALL ignore req_* while req_ready=0; back-to-back requests accepted on the edge entering IDLE+1 (i.e. first IDLE cycle).

Reset
REQ-028 SHALL on rst_n=0 immediately force: state IDLE, ce_n/oe_n/we_n=1, sram_be_n all 1, sram_dq_oe=0, rsp_valid=0, rsp_rdata=0, sram_a=0, sram_dq_o=0, req_ready=0.
REQ-029 SHALL drive req_ready=1 from the first edge after rst_n deasserts; an in-flight transfer aborted by reset produces no rsp_valid.

Configuration
REQ-030 SHALL, with SRAM_CTRL_TURNAROUND_EN defined, enter TURN for 1 cycle after every read (ce_n=1, dq_oe=0, req_ready=0) before IDLE.
REQ-031 SHALL, without SRAM_CTRL_TURNAROUND_EN, go RD_ACC->IDLE directly; TURN state unreachable.

Structure
REQ-032 SHALL place the FSM state enum and a lane-count constant function (DATA_W/8) in shared package sram_ctrl_pkg.
REQ-033 SHALL implement the loadable down-counter used by RD_ACC/WR_PULSE as sub-module sram_wait_cnt.

Verification (DATA_W=16, ADDR_W=18, RD_WAIT=1, WR_WAIT=1, against team async SRAM behavioural model)
REQ-034 SHALL write 0xBEEF to 0x00010 be=11, read back -> rsp_valid 3 edges after accept, rsp_rdata=0xBEEF.
REQ-035 SHALL write 0x12AB be=01 over 0xBEEF at 0x00010, read -> 0xBEAB; we_n low exactly 2 cycles.
REQ-036 SHALL write be=00 then read 0x3FFFF after prior 0x5A5A there -> we_n never low, read 0x5A5A.
REQ-037 SHALL issue read then write back-to-back -> with macro one TURN cycle (ce_n=1) between; without, none; oe_n/dq_oe never overlap.
REQ-038 SHALL assert rst_n=0 mid WR_PULSE -> we_n=1 and dq_oe=0 same cycle, no rsp_valid, req_ready=1 one edge after release.
